// File: rtl/phase_sequencer_if.sv
// Signal bundle between the phase sequencer and its surroundings: run controls, IR/ACC status
// and memory handshake in; datapath strobes, status flags and phase/retire count out.
interface phase_sequencer_if #(
  parameter int unsigned OPC_W    = 3,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned CNT_W    = 16
);
  logic                i_en;
  logic                i_resume;
  logic [OPC_W-1:0]    i_opcode;
  logic                i_zero;
  logic                i_mem_ready;

  logic                o_sel;
  logic                o_rd;
  logic                o_wr;
  logic                o_ld_ir;
  logic                o_ld_ac;
  logic                o_inc_pc;
  logic                o_ld_pc;
  logic                o_data_e;
  logic [ALU_OP_W-1:0] o_alu_op;
  logic                o_halt;
  logic                o_bus_err;
  logic                o_illegal;
  logic [2:0]          o_phase;
  logic [CNT_W-1:0]    o_instr_cnt;

  modport master (
    output i_en, i_resume, i_opcode, i_zero, i_mem_ready,
    input  o_sel, o_rd, o_wr, o_ld_ir, o_ld_ac, o_inc_pc, o_ld_pc, o_data_e,
    input  o_alu_op, o_halt, o_bus_err, o_illegal, o_phase, o_instr_cnt
  );

  modport slave (
    input  i_en, i_resume, i_opcode, i_zero, i_mem_ready,
    output o_sel, o_rd, o_wr, o_ld_ir, o_ld_ac, o_inc_pc, o_ld_pc, o_data_e,
    output o_alu_op, o_halt, o_bus_err, o_illegal, o_phase, o_instr_cnt
  );
endinterface

// File: rtl/phase_sequencer.sv
// Eight-phase control sequencer for the accumulator CPU: per-phase datapath strobes, memory
// wait handling with stall timeout, sticky halt/resume, illegal-opcode trap and retire counter.
module phase_sequencer #(
  parameter int unsigned OPC_W    = 3,
  parameter int unsigned ALU_OP_W = 2,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned CNT_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  phase_sequencer_if.slave bus
);

  localparam int unsigned SCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    PhInstAddr  = 3'd0,
    PhInstFetch = 3'd1,
    PhInstLoad  = 3'd2,
    PhIdle      = 3'd3,
    PhOpAddr    = 3'd4,
    PhOpFetch   = 3'd5,
    PhAluOp     = 3'd6,
    PhStore     = 3'd7
  } phase_e;

  phase_e              r_phase;
  logic                r_halt;
  logic                r_bus_err;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_instr_cnt;
  logic [SCNT_W-1:0]   r_stall_cnt;

  logic [31:0]         w_opc;
  logic                w_hlt;
  logic                w_skz;
  logic                w_sto;
  logic                w_jmp;
  logic                w_aluop;
  logic                w_bad_op;
  logic                w_stall;
  logic                w_adv;
  logic                w_trap;
  logic                w_timeout;

  // Decode on a zero-extended copy so the >= 8 test stays meaningful for any OPC_W.
  assign w_opc    = 32'(bus.i_opcode);
  assign w_hlt    = (w_opc == 32'd0);
  assign w_skz    = (w_opc == 32'd1);
  assign w_sto    = (w_opc == 32'd6);
  assign w_jmp    = (w_opc == 32'd7);
  assign w_aluop  = (w_opc >= 32'd2) && (w_opc <= 32'd5);
  assign w_bad_op = (w_opc >= 32'd8);

  assign w_stall = !bus.i_mem_ready &&
                   ((r_phase == PhInstFetch) ||
                    ((r_phase == PhOpFetch) && w_aluop) ||
                    ((r_phase == PhStore) && w_sto));
  assign w_adv     = bus.i_en && !r_halt && !w_stall;
  assign w_trap    = (r_phase == PhOpAddr) && (w_hlt || w_bad_op);
  assign w_timeout = (TIMEOUT != 0) && (r_stall_cnt == SCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= PhInstAddr;
      r_halt      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_illegal   <= 1'b0;
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (r_halt) begin
      r_phase     <= PhInstAddr;
      r_stall_cnt <= '0;
      if (bus.i_resume && !r_bus_err) begin
        r_halt <= 1'b0;
      end
    end else if (w_adv) begin
      r_stall_cnt <= '0;
      if (w_trap) begin
        r_halt  <= 1'b1;
        r_phase <= PhInstAddr;
        if (w_bad_op) begin
          r_illegal <= 1'b1;
        end
      end else begin
        r_phase <= phase_e'(r_phase + 3'd1);
        if (r_phase == PhStore) begin
          r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
      end
    end else if (w_stall && bus.i_en) begin
      if (w_timeout) begin
        r_bus_err   <= 1'b1;
        r_halt      <= 1'b1;
        r_phase     <= PhInstAddr;
        r_stall_cnt <= '0;
      end else begin
        r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
      end
    end
  end

  // Level strobes hold through stalls; load/increment strobes are edge-qualified by w_adv.
  always_comb begin
    bus.o_sel    = 1'b0;
    bus.o_rd     = 1'b0;
    bus.o_wr     = 1'b0;
    bus.o_ld_ir  = 1'b0;
    bus.o_ld_ac  = 1'b0;
    bus.o_inc_pc = 1'b0;
    bus.o_ld_pc  = 1'b0;
    bus.o_data_e = 1'b0;
    unique case (r_phase)
      PhInstAddr: bus.o_sel = 1'b1;
      PhInstFetch: begin
        bus.o_sel = 1'b1;
        bus.o_rd  = 1'b1;
      end
      PhInstLoad, PhIdle: begin
        bus.o_sel   = 1'b1;
        bus.o_rd    = 1'b1;
        bus.o_ld_ir = w_adv;
      end
      PhOpAddr:  bus.o_inc_pc = w_adv;
      PhOpFetch: bus.o_rd     = w_aluop;
      PhAluOp: begin
        bus.o_rd     = w_aluop;
        bus.o_inc_pc = w_adv && w_skz && bus.i_zero;
        bus.o_ld_pc  = w_adv && w_jmp;
        bus.o_data_e = w_sto;
      end
      PhStore: begin
        bus.o_rd     = w_aluop;
        bus.o_ld_ac  = w_adv && w_aluop;
        bus.o_ld_pc  = w_adv && w_jmp;
        bus.o_wr     = w_sto;
        bus.o_data_e = w_sto;
      end
      default: ;
    endcase
    if (r_halt) begin
      bus.o_sel    = 1'b0;
      bus.o_rd     = 1'b0;
      bus.o_wr     = 1'b0;
      bus.o_data_e = 1'b0;
    end
  end

  always_comb begin
    bus.o_alu_op = '0;
    case (w_opc)
      32'd2:   bus.o_alu_op = ALU_OP_W'(1);
      32'd3:   bus.o_alu_op = ALU_OP_W'(2);
      32'd4:   bus.o_alu_op = ALU_OP_W'(3);
      default: bus.o_alu_op = '0;
    endcase
  end

  assign bus.o_halt      = r_halt;
  assign bus.o_bus_err   = r_bus_err;
  assign bus.o_illegal   = r_illegal;
  assign bus.o_phase     = r_phase;
  assign bus.o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed-vector scoreboard bench for phase_sequencer (OPC_W=4 so illegal opcodes are reachable).
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_sequencer_if #(.OPC_W(4), .ALU_OP_W(2), .CNT_W(16)) bus ();

  phase_sequencer #(
    .OPC_W(4),
    .ALU_OP_W(2),
    .TIMEOUT(15),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // {phase, sel rd wr ld_ir ld_ac inc_pc ld_pc data_e, alu_op, halt bus_err illegal, instr_cnt}
  logic [31:0] obs;
  assign obs = {bus.o_phase, bus.o_sel, bus.o_rd, bus.o_wr, bus.o_ld_ir, bus.o_ld_ac,
                bus.o_inc_pc, bus.o_ld_pc, bus.o_data_e, bus.o_alu_op, bus.o_halt,
                bus.o_bus_err, bus.o_illegal, bus.o_instr_cnt};

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_total = 0;
  int          n_pass  = 0;

  // Strobe patterns {sel rd wr ld_ir ld_ac inc_pc ld_pc data_e}
  localparam logic [7:0] S_NONE = 8'b0000_0000;
  localparam logic [7:0] S_SEL  = 8'b1000_0000;
  localparam logic [7:0] S_FET  = 8'b1100_0000;
  localparam logic [7:0] S_LDIR = 8'b1101_0000;
  localparam logic [7:0] S_INC  = 8'b0000_0100;
  localparam logic [7:0] S_RD   = 8'b0100_0000;
  localparam logic [7:0] S_LDAC = 8'b0100_1000;
  localparam logic [7:0] S_LDPC = 8'b0000_0010;
  localparam logic [7:0] S_DE   = 8'b0000_0001;
  localparam logic [7:0] S_WR   = 8'b0010_0001;

  task automatic cyc(input string nm, input logic rn, input logic en, input logic res,
                     input logic [3:0] opc, input logic z, input logic mr,
                     input logic [2:0] ph, input logic [7:0] st, input logic [1:0] alu,
                     input logic [2:0] fl, input logic [15:0] cnt);
    @(negedge clk);
    rst_n           = rn;
    bus.i_en        = en;
    bus.i_resume    = res;
    bus.i_opcode    = opc;
    bus.i_zero      = z;
    bus.i_mem_ready = mr;
    exp_q.push_back({ph, st, alu, fl, cnt});
    name_q.push_back(nm);
  endtask

  // Immediate check of selected output fields against an expected pattern.
  task automatic check_now(input string nm, input logic [31:0] mask, input logic [31:0] want);
    #2;
    n_total++;
    if ((obs & mask) === (want & mask)) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, want %h (mask %h)", nm, obs & mask, want & mask, mask);
    end
  endtask

  // Normal no-wait instruction: phases 0..7, strobes per phase given by caller's opcode class.
  task automatic run_instr(input string nm, input logic [3:0] opc, input logic z,
                           input logic [7:0] s5, input logic [7:0] s6, input logic [7:0] s7,
                           input logic [1:0] alu, input logic [15:0] cnt);
    cyc({nm, "_p0"}, 1, 1, 0, opc, z, 1, 3'd0, S_SEL,  alu, 3'b000, cnt);
    cyc({nm, "_p1"}, 1, 1, 0, opc, z, 1, 3'd1, S_FET,  alu, 3'b000, cnt);
    cyc({nm, "_p2"}, 1, 1, 0, opc, z, 1, 3'd2, S_LDIR, alu, 3'b000, cnt);
    cyc({nm, "_p3"}, 1, 1, 0, opc, z, 1, 3'd3, S_LDIR, alu, 3'b000, cnt);
    cyc({nm, "_p4"}, 1, 1, 0, opc, z, 1, 3'd4, S_INC,  alu, 3'b000, cnt);
    cyc({nm, "_p5"}, 1, 1, 0, opc, z, 1, 3'd5, s5,     alu, 3'b000, cnt);
    cyc({nm, "_p6"}, 1, 1, 0, opc, z, 1, 3'd6, s6,     alu, 3'b000, cnt);
    cyc({nm, "_p7"}, 1, 1, 0, opc, z, 1, 3'd7, s7,     alu, 3'b000, cnt);
  endtask

  // Monitor: every cycle with a pending expectation, compare just after the input update.
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        n_total++;
        if (obs === e) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got ph=%0d strb=%b alu=%0d flags=%b cnt=%0d, want ph=%0d strb=%b alu=%0d flags=%b cnt=%0d",
                   n, obs[31:29], obs[28:21], obs[20:19], obs[18:16], obs[15:0],
                   e[31:29], e[28:21], e[20:19], e[18:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    bus.i_en = 0; bus.i_resume = 0; bus.i_opcode = '0; bus.i_zero = 0; bus.i_mem_ready = 1;

    cyc("reset", 0, 1, 0, 4'd0, 0, 1, 3'd0, S_SEL, 2'd0, 3'b000, 16'd0);
    check_now("reset_state", 32'hFFFF_FFFF, {3'd0, S_SEL, 2'd0, 3'b000, 16'd0});

    run_instr("lda",   4'd5, 0, S_RD,   S_RD,   S_LDAC, 2'd0, 16'd0);
    run_instr("skz_z", 4'd1, 1, S_NONE, S_INC,  S_NONE, 2'd0, 16'd1);
    run_instr("skz_n", 4'd1, 0, S_NONE, S_NONE, S_NONE, 2'd0, 16'd2);
    run_instr("jmp",   4'd7, 0, S_NONE, S_LDPC, S_LDPC, 2'd0, 16'd3);
    run_instr("add",   4'd2, 0, S_RD,   S_RD,   S_LDAC, 2'd1, 16'd4);

    // STO with three wait cycles in phase 7
    cyc("sto_p0", 1, 1, 0, 4'd6, 0, 1, 3'd0, S_SEL,  2'd0, 3'b000, 16'd5);
    cyc("sto_p1", 1, 1, 0, 4'd6, 0, 1, 3'd1, S_FET,  2'd0, 3'b000, 16'd5);
    cyc("sto_p2", 1, 1, 0, 4'd6, 0, 1, 3'd2, S_LDIR, 2'd0, 3'b000, 16'd5);
    cyc("sto_p3", 1, 1, 0, 4'd6, 0, 1, 3'd3, S_LDIR, 2'd0, 3'b000, 16'd5);
    cyc("sto_p4", 1, 1, 0, 4'd6, 0, 1, 3'd4, S_INC,  2'd0, 3'b000, 16'd5);
    cyc("sto_p5", 1, 1, 0, 4'd6, 0, 0, 3'd5, S_NONE, 2'd0, 3'b000, 16'd5);
    cyc("sto_p6", 1, 1, 0, 4'd6, 0, 1, 3'd6, S_DE,   2'd0, 3'b000, 16'd5);
    for (int i = 0; i < 3; i++) begin
      cyc("sto_wait", 1, 1, 0, 4'd6, 0, 0, 3'd7, S_WR, 2'd0, 3'b000, 16'd5);
    end
    cyc("sto_p7",  1, 1, 0, 4'd6, 0, 1, 3'd7, S_WR, 2'd0, 3'b000, 16'd5);

    // XOR with en dropped in phase 2
    cyc("xor_p0",  1, 1, 0, 4'd4, 0, 1, 3'd0, S_SEL,  2'd3, 3'b000, 16'd6);
    cyc("xor_p1",  1, 1, 0, 4'd4, 0, 1, 3'd1, S_FET,  2'd3, 3'b000, 16'd6);
    cyc("xor_en0", 1, 0, 0, 4'd4, 0, 1, 3'd2, S_FET,  2'd3, 3'b000, 16'd6);
    cyc("xor_en0", 1, 0, 0, 4'd4, 0, 1, 3'd2, S_FET,  2'd3, 3'b000, 16'd6);
    cyc("xor_p2",  1, 1, 0, 4'd4, 0, 1, 3'd2, S_LDIR, 2'd3, 3'b000, 16'd6);
    cyc("xor_p3",  1, 1, 0, 4'd4, 0, 1, 3'd3, S_LDIR, 2'd3, 3'b000, 16'd6);
    cyc("xor_p4",  1, 1, 0, 4'd4, 0, 1, 3'd4, S_INC,  2'd3, 3'b000, 16'd6);
    cyc("xor_p5",  1, 1, 0, 4'd4, 0, 1, 3'd5, S_RD,   2'd3, 3'b000, 16'd6);
    cyc("xor_p6",  1, 1, 0, 4'd4, 0, 1, 3'd6, S_RD,   2'd3, 3'b000, 16'd6);
    cyc("xor_p7",  1, 1, 0, 4'd4, 0, 1, 3'd7, S_LDAC, 2'd3, 3'b000, 16'd6);

    // HLT, then resume
    cyc("hlt_p0",  1, 1, 0, 4'd0, 0, 1, 3'd0, S_SEL,  2'd0, 3'b000, 16'd7);
    cyc("hlt_p1",  1, 1, 0, 4'd0, 0, 1, 3'd1, S_FET,  2'd0, 3'b000, 16'd7);
    cyc("hlt_p2",  1, 1, 0, 4'd0, 0, 1, 3'd2, S_LDIR, 2'd0, 3'b000, 16'd7);
    cyc("hlt_p3",  1, 1, 0, 4'd0, 0, 1, 3'd3, S_LDIR, 2'd0, 3'b000, 16'd7);
    cyc("hlt_p4",  1, 1, 0, 4'd0, 0, 1, 3'd4, S_INC,  2'd0, 3'b000, 16'd7);
    cyc("halted",  1, 1, 0, 4'd0, 0, 1, 3'd0, S_NONE, 2'd0, 3'b100, 16'd7);
    cyc("halted",  1, 0, 0, 4'd0, 0, 1, 3'd0, S_NONE, 2'd0, 3'b100, 16'd7);
    cyc("resume",  1, 1, 1, 4'd0, 0, 1, 3'd0, S_NONE, 2'd0, 3'b100, 16'd7);
    cyc("rs_p0",   1, 1, 0, 4'd9, 0, 1, 3'd0, S_SEL,  2'd0, 3'b000, 16'd7);
    cyc("rs_p1",   1, 1, 0, 4'd9, 0, 1, 3'd1, S_FET,  2'd0, 3'b000, 16'd7);

    // Illegal opcode 9
    cyc("ill_p2",  1, 1, 0, 4'd9, 0, 1, 3'd2, S_LDIR, 2'd0, 3'b000, 16'd7);
    cyc("ill_p3",  1, 1, 0, 4'd9, 0, 1, 3'd3, S_LDIR, 2'd0, 3'b000, 16'd7);
    cyc("ill_p4",  1, 1, 0, 4'd9, 0, 1, 3'd4, S_INC,  2'd0, 3'b000, 16'd7);
    cyc("ill_hlt", 1, 1, 0, 4'd9, 0, 1, 3'd0, S_NONE, 2'd0, 3'b101, 16'd7);
    cyc("ill_res", 1, 1, 1, 4'd9, 0, 1, 3'd0, S_NONE, 2'd0, 3'b101, 16'd7);
    cyc("ill_run", 1, 1, 0, 4'd5, 0, 0, 3'd0, S_SEL,  2'd0, 3'b001, 16'd7);

    // Stall timeout in phase 1
    for (int i = 0; i < 15; i++) begin
      cyc("tmo_stall", 1, 1, 0, 4'd5, 0, 0, 3'd1, S_FET, 2'd0, 3'b001, 16'd7);
    end
    cyc("tmo_err",  1, 1, 0, 4'd5, 0, 0, 3'd0, S_NONE, 2'd0, 3'b111, 16'd7);
    check_now("expired_wait", 32'hFFFF_0000, {3'd0, S_NONE, 2'd0, 3'b111, 16'd0});
    cyc("tmo_res",  1, 1, 1, 4'd5, 0, 1, 3'd0, S_NONE, 2'd0, 3'b111, 16'd7);
    cyc("tmo_stay", 1, 1, 0, 4'd5, 0, 1, 3'd0, S_NONE, 2'd0, 3'b111, 16'd7);

    // Reset clears sticky flags; then reset mid-phase-5 stall
    cyc("rst2",    0, 1, 0, 4'd2, 0, 1, 3'd0, S_SEL,  2'd1, 3'b000, 16'd0);
    cyc("r_p0",    1, 1, 0, 4'd2, 0, 1, 3'd0, S_SEL,  2'd1, 3'b000, 16'd0);
    cyc("r_p1",    1, 1, 0, 4'd2, 0, 1, 3'd1, S_FET,  2'd1, 3'b000, 16'd0);
    cyc("r_p2",    1, 1, 0, 4'd2, 0, 1, 3'd2, S_LDIR, 2'd1, 3'b000, 16'd0);
    cyc("r_p3",    1, 1, 0, 4'd2, 0, 1, 3'd3, S_LDIR, 2'd1, 3'b000, 16'd0);
    cyc("r_p4",    1, 1, 0, 4'd2, 0, 1, 3'd4, S_INC,  2'd1, 3'b000, 16'd0);
    cyc("r_p5w",   1, 1, 0, 4'd2, 0, 0, 3'd5, S_RD,   2'd1, 3'b000, 16'd0);
    cyc("rst_mid", 0, 1, 0, 4'd0, 0, 0, 3'd0, S_SEL,  2'd0, 3'b000, 16'd0);
    cyc("post_p0", 1, 1, 0, 4'd5, 0, 1, 3'd0, S_SEL,  2'd0, 3'b000, 16'd0);
    cyc("post_p1", 1, 1, 0, 4'd5, 0, 1, 3'd1, S_FET,  2'd0, 3'b000, 16'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
